// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand forwarding into EX plus load-use stall control for a 5-stage pipe.
//   Each EX read port gets data from MEM, WB, or a "late buffer" that captures
//   WB writes which landed while the consumer sat stalled in ID (and so would
//   otherwise be missed once MEM/WB move on).
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 redirect from EX; kills ID and any stall in progress
//   rf_we/wa/wd_mem|wb    MEM and WB register-file write ports
//   ex_is_load, ex_we,
//   ex_wa                 EX instruction load flag / write enable / dest reg
//   id_ra, ex_ra          packed read addresses, port p at [5p+4:5p]
//   id_re                 ID read-port used flags
//   rf_rd_fe, rf_rd_fd    per-port forward enable / packed forward data
//   stall_pc, stall_if_id hold PC and IF/ID
//   flush_id_ex           bubble into ID/EX
//   busy                  stall FSM is in STALL
//
// state   | meaning
// S_IDLE  | no stall in progress; load-use hazard checked here
// S_STALL | extra load-latency stall cycles, cnt counts down to 1

module hazard_forward_unit #(
    parameter int NRP      = 2,
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  rf_we_mem,
    input  logic                  rf_we_wb,
    input  logic [4:0]            rf_wa_mem,
    input  logic [4:0]            rf_wa_wb,
    input  logic [XLEN-1:0]       rf_wd_mem,
    input  logic [XLEN-1:0]       rf_wd_wb,
    input  logic                  ex_is_load,
    input  logic                  ex_we,
    input  logic [4:0]            ex_wa,
    input  logic [5*NRP-1:0]      id_ra,
    input  logic [5*NRP-1:0]      ex_ra,
    input  logic [NRP-1:0]        id_re,
    output logic [NRP-1:0]        rf_rd_fe,
    output logic [XLEN*NRP-1:0]   rf_rd_fd,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  flush_id_ex,
    output logic                  busy
);

    typedef enum logic {S_IDLE, S_STALL} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [NRP-1:0]  idv_q, idv_d;
    logic [XLEN-1:0] idd_q [NRP];
    logic [XLEN-1:0] idd_d [NRP];
    logic [NRP-1:0]  exv_q, exv_d;
    logic [XLEN-1:0] exd_q [NRP];
    logic [XLEN-1:0] exd_d [NRP];

    logic mem_ok, wb_ok, hazard, stall;

    // Control: hazard detection, stall outputs, FSM next state
    always_comb begin
        mem_ok = rf_we_mem && (rf_wa_mem != 5'd0);
        wb_ok  = rf_we_wb  && (rf_wa_wb  != 5'd0);

        hazard = 1'b0;
        if (state_q == S_IDLE && ex_is_load && ex_we && ex_wa != 5'd0) begin
            for (int p = 0; p < NRP; p++) begin
                if (id_re[p] && id_ra[5*p +: 5] == ex_wa)
                    hazard = 1'b1;
            end
        end

        // flush overrides any stall, including one detected this cycle
        stall       = !flush && (state_q == S_STALL || hazard);
        stall_pc    = stall;
        stall_if_id = stall;
        flush_id_ex = stall || flush;
        busy        = (state_q == S_STALL);

        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end else if (state_q == S_IDLE) begin
            if (hazard && LOAD_LAT > 1) begin
                state_d = S_STALL;
                cnt_d   = CNT_INIT;
            end
        end else begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1)
                state_d = S_IDLE;
        end
    end

    // Late buffers and forwarding mux
    always_comb begin
        rf_rd_fe = '0;
        rf_rd_fd = '0;
        for (int p = 0; p < NRP; p++) begin
            idv_d[p] = 1'b0;
            idd_d[p] = '0;
            if (stall) begin
                idv_d[p] = idv_q[p];
                idd_d[p] = idd_q[p];
                if (wb_ok && id_re[p] && rf_wa_wb == id_ra[5*p +: 5]) begin
                    idv_d[p] = 1'b1;
                    idd_d[p] = rf_wd_wb;
                end
            end

            // ID buffer follows the instruction into EX when ID advances
            exv_d[p] = 1'b0;
            exd_d[p] = '0;
            if (!stall && !flush) begin
                exv_d[p] = idv_q[p];
                exd_d[p] = idd_q[p];
            end

            if (mem_ok && rf_wa_mem == ex_ra[5*p +: 5]) begin
                rf_rd_fe[p]                = 1'b1;
                rf_rd_fd[XLEN*p +: XLEN]   = rf_wd_mem;
            end else if (wb_ok && rf_wa_wb == ex_ra[5*p +: 5]) begin
                rf_rd_fe[p]                = 1'b1;
                rf_rd_fd[XLEN*p +: XLEN]   = rf_wd_wb;
            end else if (exv_q[p]) begin
                rf_rd_fe[p]                = 1'b1;
                rf_rd_fd[XLEN*p +: XLEN]   = exd_q[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idv_q   <= '0;
            exv_q   <= '0;
            for (int p = 0; p < NRP; p++) begin
                idd_q[p] <= '0;
                exd_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idv_q   <= idv_d;
            exv_q   <= exv_d;
            for (int p = 0; p < NRP; p++) begin
                idd_q[p] <= idd_d[p];
                exd_q[p] <= exd_d[p];
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int NRP      = 2;
    localparam int XLEN     = 32;
    localparam int LOAD_LAT = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                rf_we_mem, rf_we_wb;
    logic [4:0]          rf_wa_mem, rf_wa_wb;
    logic [XLEN-1:0]     rf_wd_mem, rf_wd_wb;
    logic                ex_is_load, ex_we;
    logic [4:0]          ex_wa;
    logic [5*NRP-1:0]    id_ra, ex_ra;
    logic [NRP-1:0]      id_re;
    logic [NRP-1:0]      rf_rd_fe;
    logic [XLEN*NRP-1:0] rf_rd_fd;
    logic                stall_pc, stall_if_id, flush_id_ex, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NRP(NRP), .XLEN(XLEN), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .rf_we_mem(rf_we_mem), .rf_we_wb(rf_we_wb),
        .rf_wa_mem(rf_wa_mem), .rf_wa_wb(rf_wa_wb),
        .rf_wd_mem(rf_wd_mem), .rf_wd_wb(rf_wd_wb),
        .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_wa(ex_wa),
        .id_ra(id_ra), .ex_ra(ex_ra), .id_re(id_re),
        .rf_rd_fe(rf_rd_fe), .rf_rd_fd(rf_rd_fd),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .flush_id_ex(flush_id_ex), .busy(busy)
    );

    typedef struct {
        logic        we_mem;
        logic [4:0]  wa_mem;
        logic [31:0] wd_mem;
        logic        we_wb;
        logic [4:0]  wa_wb;
        logic [31:0] wd_wb;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  fe;
        logic [31:0] fd0;
        logic [31:0] fd1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; rf_we_mem = 0; rf_we_wb = 0; rf_wa_mem = 0; rf_wa_wb = 0;
        rf_wd_mem = 0; rf_wd_wb = 0; ex_is_load = 0; ex_we = 0; ex_wa = 0;
        id_ra = 0; ex_ra = 0; id_re = 0;
    endtask

    // Load to x5 in EX, ID reads x5 on port 0
    task automatic set_hazard();
        ex_is_load = 1; ex_we = 1; ex_wa = 5'd5;
        id_ra = {5'd0, 5'd5}; id_re = 2'b01;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'h11,   1'b1, 5'd3,  32'h22,   5'd3,  5'd7,  2'b01, 32'h11,   32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hFF,   5'd0,  5'd0,  2'b00, 32'h0,    32'h0};
        vecs[2] = '{1'b0, 5'd4,  32'hAA,   1'b1, 5'd4,  32'hBB,   5'd4,  5'd4,  2'b11, 32'hBB,   32'hBB};
        vecs[3] = '{1'b1, 5'd6,  32'h66,   1'b1, 5'd9,  32'h99,   5'd9,  5'd6,  2'b11, 32'h99,   32'h66};
        vecs[4] = '{1'b1, 5'd0,  32'h77,   1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  2'b00, 32'h0,    32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hDEAD, 1'b1, 5'd31, 32'hBEEF, 5'd31, 5'd30, 2'b01, 32'hDEAD, 32'h0};
        vecs[6] = '{1'b1, 5'd2,  32'h5,    1'b1, 5'd8,  32'h6,    5'd1,  5'd1,  2'b00, 32'h0,    32'h0};

        clear_inputs();
        rst_n = 0;
        step(); step();
        chk("reset_fe", {30'd0, rf_rd_fe}, 32'd0);
        chk("reset_fd0", rf_rd_fd[31:0], 32'd0);
        chk("reset_fd1", rf_rd_fd[63:32], 32'd0);
        chk("reset_stall", {29'd0, stall_pc, stall_if_id, flush_id_ex}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1;
        step();

        // Combinational forwarding table
        for (int i = 0; i < 7; i++) begin
            rf_we_mem = vecs[i].we_mem; rf_wa_mem = vecs[i].wa_mem; rf_wd_mem = vecs[i].wd_mem;
            rf_we_wb  = vecs[i].we_wb;  rf_wa_wb  = vecs[i].wa_wb;  rf_wd_wb  = vecs[i].wd_wb;
            ex_ra = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_fe", i), {30'd0, rf_rd_fe}, {30'd0, vecs[i].fe});
            chk($sformatf("vec%0d_fd0", i), rf_rd_fd[31:0], vecs[i].fd0);
            chk($sformatf("vec%0d_fd1", i), rf_rd_fd[63:32], vecs[i].fd1);
            step();
        end

        // Load-use stall of LOAD_LAT cycles, WB write captured during stall
        clear_inputs();
        set_hazard();
        #1;
        chk("s1_stall_pc", {31'd0, stall_pc}, 32'd1);
        chk("s1_stall_if_id", {31'd0, stall_if_id}, 32'd1);
        chk("s1_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        chk("s1_busy", {31'd0, busy}, 32'd0);
        step();
        ex_is_load = 0; ex_we = 0;
        rf_we_wb = 1; rf_wa_wb = 5'd5; rf_wd_wb = 32'hABCD;
        #1;
        chk("s2_stall_pc", {31'd0, stall_pc}, 32'd1);
        chk("s2_busy", {31'd0, busy}, 32'd1);
        step();
        rf_we_wb = 0; rf_wa_wb = 0; rf_wd_wb = 0;
        #1;
        chk("s3_stall_pc", {31'd0, stall_pc}, 32'd1);
        chk("s3_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        chk("s3_busy", {31'd0, busy}, 32'd1);
        step();
        ex_ra = {5'd0, 5'd5};
        #1;
        chk("s4_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("s4_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
        chk("s4_busy", {31'd0, busy}, 32'd0);
        chk("s4_fe_early", {30'd0, rf_rd_fe}, 32'd0);
        step();
        #1;
        chk("s5_late_fe", {30'd0, rf_rd_fe}, 32'd1);
        chk("s5_late_fd0", rf_rd_fd[31:0], 32'hABCD);
        step();
        #1;
        chk("s6_late_gone", {30'd0, rf_rd_fe}, 32'd0);

        // Flush in second stall cycle
        clear_inputs();
        step();
        set_hazard();
        rf_we_wb = 1; rf_wa_wb = 5'd5; rf_wd_wb = 32'h1234;
        step();
        ex_is_load = 0; ex_we = 0; rf_we_wb = 0; rf_wa_wb = 0;
        flush = 1;
        #1;
        chk("fl_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("fl_stall_if_id", {31'd0, stall_if_id}, 32'd0);
        chk("fl_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        step();
        flush = 0; ex_ra = {5'd0, 5'd5};
        #1;
        chk("fl_busy_after", {31'd0, busy}, 32'd0);
        chk("fl_stall_after", {31'd0, stall_pc}, 32'd0);
        chk("fl_fe_after", {30'd0, rf_rd_fe}, 32'd0);
        step();
        #1;
        chk("fl_fe_after2", {30'd0, rf_rd_fe}, 32'd0);

        // Hazard and flush in the same cycle: flush wins
        clear_inputs();
        step();
        set_hazard();
        flush = 1;
        #1;
        chk("hf_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("hf_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        step();
        clear_inputs();
        #1;
        chk("hf_busy_next", {31'd0, busy}, 32'd0);
        chk("hf_stall_next", {31'd0, stall_if_id}, 32'd0);

        // Reset in the middle of a stall
        step();
        set_hazard();
        rf_we_wb = 1; rf_wa_wb = 5'd5; rf_wd_wb = 32'h5555;
        step();
        ex_is_load = 0; ex_we = 0; rf_we_wb = 0; rf_wa_wb = 0;
        #1;
        chk("rs_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 0;
        step();
        rst_n = 1; ex_ra = {5'd5, 5'd5};
        #1;
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_stall", {29'd0, stall_pc, stall_if_id, flush_id_ex}, 32'd0);
        chk("rs_fe", {30'd0, rf_rd_fe}, 32'd0);
        step();
        #1;
        chk("rs_fe2", {30'd0, rf_rd_fe}, 32'd0);
        chk("rs_busy2", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter: NRP, 2, number of register read ports per instruction (1..4).
REQ-002 Parameter: XLEN, 32, data width.
REQ-003 Parameter: LOAD_LAT, 1, load-use stall cycles (1..4).
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: flush  in  1  branch/jump redirect from EX; kills ID and stall sequence.
REQ-007 Port: rf_we_mem, rf_we_wb  in  1 each  write enables of MEM and WB stages.
REQ-008 Port: rf_wa_mem, rf_wa_wb  in  5 each  destination registers of MEM and WB.
REQ-009 Port: rf_wd_mem, rf_wd_wb  in  XLEN each  write data of MEM and WB.
REQ-010 Port: ex_is_load, ex_we  in  1 each  EX instruction is a load / writes RF.
REQ-011 Port: ex_wa  in  5  EX destination register.
REQ-012 Port: id_ra, ex_ra  in  5*NRP each  packed ID/EX read addresses, port p at [5p+4:5p].
REQ-013 Port: id_re  in  NRP  ID read-port used flags.
REQ-014 Port: rf_rd_fe  out  NRP  per-port forward enable for EX.
REQ-015 Port: rf_rd_fd  out  XLEN*NRP  packed per-port forward data (port p at [XLEN*p+XLEN-1:XLEN*p]).
REQ-016 Port: stall_pc, stall_if_id  out  1 each  hold PC and IF/ID register.
REQ-017 Port: flush_id_ex  out  1  insert bubble into ID/EX.
REQ-018 Port: busy  out  1  stall FSM in STALL state.

Function
REQ-019 A write is valid (we_ok) only if its enable is 1 and its address is nonzero; x0 is never forwarded nor hazard-checked.
REQ-020 Per EX port p, forward priority SHALL be: MEM match > WB match > EX late buffer valid > none; on none, fe[p]=0 and fd[p]=0.
REQ-021 Forwarding SHALL be combinational, zero-cycle latency.
REQ-022 Load-use hazard = ex_is_load & ex_we & ex_wa!=0 & some p with id_re[p] & id_ra[p]==ex_wa, evaluated only in IDLE.
REQ-023 FSM states IDLE, STALL; 2-bit down-counter cnt.
REQ-024 IDLE with hazard and flush=0: stall_pc=stall_if_id=flush_id_ex=1 that cycle; if LOAD_LAT>1 go to STALL with cnt=LOAD_LAT-1, else stay IDLE.
REQ-025 STALL: all three stall outputs=1 and busy=1; cnt decrements each cycle; at cnt==1 return to IDLE; total stall = exactly LOAD_LAT cycles.
REQ-026 flush=1 in any state: next state IDLE, cnt=0, stall outputs deasserted that cycle, flush_id_ex=1, all late buffers cleared.
REQ-027 ID late buffer per port (v, d): during any cycle with stall_if_id=1, a valid WB write with rf_wa_wb==id_ra[p] and id_re[p]=1 loads d=rf_wd_wb, v=1; later matches overwrite.
REQ-028 EX late buffer per port: each cycle, if stall_if_id=0 and flush=0 it loads the ID buffer contents, else clears to v=0; ID buffer clears whenever stall_if_id=0.
REQ-029 Simultaneous MEM and WB match on same address: MEM wins; simultaneous hazard and flush: flush wins.

Reset
REQ-030 rst_n=0 at a clock edge: FSM IDLE, cnt=0, all buffer valid and data bits 0; outputs rf_rd_fe=0, rf_rd_fd=0, stall/flush/busy=0 after the edge.
REQ-031 Reset mid-STALL SHALL abandon the stall with no residual stall cycle.

Verification
REQ-032 MEM we=1 wa=3 wd=0x11, WB we=1 wa=3 wd=0x22, ex_ra[0]=3 -> fe[0]=1, fd[0]=0x11.
REQ-033 WB write wa=0 wd=0xFF, ex_ra[1]=0 -> fe[1]=0, fd[1]=0.
REQ-034 LOAD_LAT=3, EX load to x5, id_ra[0]=5, id_re[0]=1 -> stall_pc and flush_id_ex high exactly 3 cycles, busy high cycles 2-3.
REQ-035 LOAD_LAT=3, during stall WB writes x5=0xABCD -> after release EX port 0 sees fe=1, fd=0xABCD when MEM/WB no longer match.
REQ-036 flush=1 in second STALL cycle -> stalls drop same cycle, FSM IDLE next, buffers v=0.
REQ-037 rst_n=0 during STALL -> next cycle busy=0, stall outputs 0, fe all 0.
